// File: rtl/avg_frame_writer_pkg.sv
// Shared definitions for the averaged-frame writer: default geometry shared with
// the row-averaging stage, the writer FSM state type and a width helper.
package avg_frame_writer_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_ROWS       = 15;
  localparam int DEF_COLS       = 8;
  localparam int DEF_ADDR_W     = 7;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int FRAME_PIXELS   = DEF_ROWS * DEF_COLS;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } wrState_e;

  // Counter width that stays at least one bit for degenerate dimensions.
  function automatic int ceilLog2(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/avg_sync_fifo.sv
// Small registered synchronous FIFO (no bypass) used as the elastic buffer in
// front of the result memory; caller guarantees push/pop are already qualified.
module avg_sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] storage [FIFO_DEPTH];
  logic [PTR_W:0]    wrPtr_q, wrPtr_d;
  logic [PTR_W:0]    rdPtr_q, rdPtr_d;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wrPtr_q == rdPtr_q);
  assign full  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                 (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
  assign rdata = storage[rdPtr_q[PTR_W-1:0]];

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (push) wrPtr_d = wrPtr_q + 1'b1;
    if (pop)  rdPtr_d = rdPtr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) storage[wrPtr_q[PTR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/avg_frame_writer.sv
// Buffers the averaged pixel stream and writes one frame into the result memory
// in raster order. Optional frame-maximum tracking is enabled by AVG_FRAME_MAX_EN.
module avg_frame_writer
  import avg_frame_writer_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              mem_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              done,
  output logic              overflow,
  output logic [DATA_W-1:0] frame_max
);

  localparam int ROW_W = ceilLog2(ROWS);
  localparam int COL_W = ceilLog2(COLS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  wrState_e          state_q, state_d;
  logic [ROW_W-1:0]  rowCnt_q, rowCnt_d;
  logic [COL_W-1:0]  colCnt_q, colCnt_d;
  logic [ADDR_W-1:0] lastAddr_q;
  logic [DATA_W-1:0] lastData_q;
  logic              overflow_q;

  logic              fifoFull, fifoEmpty, fifoPush;
  logic [DATA_W-1:0] fifoRdata;
  logic              memWen, writeAccept, lastPixel;
  logic [ADDR_W-1:0] curAddr;

  assign writeAccept = memWen && mem_ready;
  assign fifoPush    = in_valid && (!fifoFull || writeAccept);
  assign lastPixel   = (rowCnt_q == LAST_ROW) && (colCnt_q == LAST_COL);
  assign curAddr     = ADDR_W'(32'(rowCnt_q) * COLS + 32'(colCnt_q));

  avg_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifoPush),
    .pop   (writeAccept),
    .wdata (in_data),
    .rdata (fifoRdata),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  always_comb begin
    state_d = state_q;
    memWen  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifoEmpty) state_d = WRITE;
      end
      WRITE: begin
        memWen = !fifoEmpty;
        if (memWen && mem_ready && lastPixel) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    rowCnt_d = rowCnt_q;
    colCnt_d = colCnt_q;
    if (writeAccept) begin
      if (colCnt_q == LAST_COL) begin
        colCnt_d = '0;
        rowCnt_d = (rowCnt_q == LAST_ROW) ? '0 : rowCnt_q + 1'b1;
      end else begin
        colCnt_d = colCnt_q + 1'b1;
      end
    end
  end

  // Address/data are remembered so the memory bus holds still between writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rowCnt_q   <= '0;
      colCnt_q   <= '0;
      lastAddr_q <= '0;
      lastData_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rowCnt_q <= rowCnt_d;
      colCnt_q <= colCnt_d;
      if (memWen) begin
        lastAddr_q <= curAddr;
        lastData_q <= fifoRdata;
      end
      if (in_valid && fifoFull && !writeAccept) overflow_q <= 1'b1;
    end
  end

  assign mem_wen   = memWen;
  assign mem_addr  = memWen ? curAddr : lastAddr_q;
  assign mem_wdata = memWen ? fifoRdata : lastData_q;
  assign done      = (state_q == DONE);
  assign overflow  = overflow_q;

`ifdef AVG_FRAME_MAX_EN
  logic [DATA_W-1:0] runMax_q;
  logic [DATA_W-1:0] frameMax_q;

  // The last pixel is already folded into runMax_q when DONE is entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      runMax_q   <= '0;
      frameMax_q <= '0;
    end else if (state_q == DONE) begin
      frameMax_q <= runMax_q;
      runMax_q   <= '0;
    end else if (writeAccept && (fifoRdata > runMax_q)) begin
      runMax_q <= fifoRdata;
    end
  end

  assign frame_max = frameMax_q;
`else
  assign frame_max = '0;
`endif

endmodule
